// File: rtl/fair_dispatch_lane_q.sv
// dispatch_lane_q: two-entry FIFO holding words for one output lane of
// fair_dispatch. The head entry comes straight out of the storage registers,
// so it stays stable while the consumer stalls.
//
// Ports
//   clk   : clock; all state updates on its rising edge
//   rst   : synchronous reset, active low; clears pointers and occupancy
//   push  : write data into the tail (ignored when the lane is full)
//   data  : word to write on push
//   pop   : consumer takes the head (ignored when the lane is empty)
//   valid : lane holds at least one word
//   head  : oldest word in the lane
//   free  : lane can accept a word this cycle (occupancy below 2)
module dispatch_lane_q #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic         free
);

  localparam int OCC_W = 2;

  logic [W-1:0]     mem_q [2];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  // Free and valid come from the registered occupancy only, so a pop in the
  // same cycle never makes a full lane look available to the selector.
  assign free    = (occ_q < OCC_W'(2));
  assign valid   = (occ_q != '0);
  assign head    = mem_q[rd_q];
  assign do_push = push & free;
  assign do_pop  = pop & valid;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (do_push) wr_d = ~wr_q;
    if (do_pop)  rd_d = ~rd_q;
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Payload storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data;
  end

endmodule

// File: rtl/fair_dispatch.sv
// fair_dispatch: accepts one upstream word per cycle and hands it to one of
// N = 2**LG_N output lanes, each buffered by a two-entry FIFO. The lane is
// chosen round-robin: starting at r_ptr, the first lane with room wins, and
// r_ptr then moves just past the chosen lane.
//
// Ports
//   clk       : clock; all state updates on its rising edge
//   rst       : synchronous reset, active low
//   in_valid  : upstream word valid
//   in_data   : upstream payload (W bits)
//   in_ready  : some lane has room; independent of in_valid
//   out_valid : per-lane head valid (N bits)
//   out_data  : per-lane head payload, lane i in bits [i*W +: W]
//   out_ready : per-lane consumer pop (N bits)
//   sel       : {1'b0, lane} of the lane taking the word this cycle,
//               all-ones when no word is accepted
module fair_dispatch #(
  parameter int LG_N = 2,
  parameter int W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [W-1:0]            in_data,
  output logic                    in_ready,
  output logic [(1<<LG_N)-1:0]    out_valid,
  output logic [(1<<LG_N)*W-1:0]  out_data,
  input  logic [(1<<LG_N)-1:0]    out_ready,
  output logic [LG_N:0]           sel
);

  localparam int N = 1 << LG_N;

  logic [LG_N-1:0] r_ptr_q, r_ptr_d;
  logic [N-1:0]    free;
  logic [N-1:0]    free_rot;
  logic [N-1:0]    push;
  logic [LG_N-1:0] off;
  logic [LG_N-1:0] lane;
  logic            found;
  logic            xfer;

  // Rotate the free vector so bit 0 corresponds to r_ptr, pick the lowest
  // set bit, then add r_ptr back to turn the offset into a lane number.
  always_comb begin
    free_rot = '0;
    found    = 1'b0;
    off      = '0;
    for (int j = 0; j < N; j++) begin
      free_rot[j] = free[r_ptr_q + LG_N'(j)];
    end
    for (int j = 0; j < N; j++) begin
      if (!found && free_rot[j]) begin
        found = 1'b1;
        off   = LG_N'(j);
      end
    end
  end

  assign lane     = r_ptr_q + off;
  assign in_ready = found;
  assign xfer     = in_valid & in_ready;
  assign sel      = xfer ? {1'b0, lane} : {(LG_N+1){1'b1}};
  assign r_ptr_d  = xfer ? lane + LG_N'(1) : r_ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) r_ptr_q <= '0;
    else      r_ptr_q <= r_ptr_d;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign push[i] = xfer & (lane == LG_N'(i));

    dispatch_lane_q #(.W(W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .data  (in_data),
      .pop   (out_ready[i]),
      .valid (out_valid[i]),
      .head  (out_data[i*W +: W]),
      .free  (free[i])
    );
  end

endmodule

// File: tb/tb_fair_dispatch.sv
module tb_fair_dispatch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ready;
  logic [2:0]  sel;

  int nvec;
  int miscompares;

  fair_dispatch #(.LG_N(2), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [7:0]  id;
    logic [3:0]  ordy;
    logic        chk;
    logic        rdy;
    logic [2:0]  sel;
    logic [1:0]  rptr;
    logic [3:0]  ov;
    logic [31:0] od;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic [7:0] id, logic [3:0] ordy,
                              logic chk, logic rdy, logic [2:0] s, logic [1:0] rp,
                              logic [3:0] ov, logic [31:0] od);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.id = id; v.ordy = ordy; v.chk = chk;
    v.rdy = rdy; v.sel = s; v.rptr = rp; v.ov = ov; v.od = od;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s (step %0d): got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [7:0] d,
                       input logic [3:0] ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;
    nvec = 0; miscompares = 0;

    // Reset
    vecs.push_back(mk(0,0,8'h00,4'h0, 0,0,3'd7,2'd0,4'h0,32'h0));
    vecs.push_back(mk(0,0,8'h00,4'h0, 1,1,3'd7,2'd0,4'h0,32'h0));
    // Back-to-back with every consumer ready: strict rotation, 1-cycle latency
    vecs.push_back(mk(1,1,8'h10,4'hF, 1,1,3'd0,2'd0,4'h0,32'h0));
    vecs.push_back(mk(1,1,8'h11,4'hF, 1,1,3'd1,2'd1,4'h1,32'h00000010));
    vecs.push_back(mk(1,1,8'h12,4'hF, 1,1,3'd2,2'd2,4'h2,32'h00001100));
    vecs.push_back(mk(1,1,8'h13,4'hF, 1,1,3'd3,2'd3,4'h4,32'h00120000));
    vecs.push_back(mk(1,1,8'h14,4'hF, 1,1,3'd0,2'd0,4'h8,32'h13000000));
    vecs.push_back(mk(1,1,8'h15,4'hF, 1,1,3'd1,2'd1,4'h1,32'h00000014));
    vecs.push_back(mk(1,1,8'h16,4'hF, 1,1,3'd2,2'd2,4'h2,32'h00001500));
    vecs.push_back(mk(1,1,8'h17,4'hF, 1,1,3'd3,2'd3,4'h4,32'h00160000));
    vecs.push_back(mk(1,0,8'h00,4'hF, 1,1,3'd7,2'd0,4'h8,32'h17000000));
    // Fill all lanes with no consumer, then back-pressure the ninth word
    vecs.push_back(mk(1,1,8'h20,4'h0, 1,1,3'd0,2'd0,4'h0,32'h0));
    vecs.push_back(mk(1,1,8'h21,4'h0, 1,1,3'd1,2'd1,4'h1,32'h00000020));
    vecs.push_back(mk(1,1,8'h22,4'h0, 1,1,3'd2,2'd2,4'h3,32'h00002120));
    vecs.push_back(mk(1,1,8'h23,4'h0, 1,1,3'd3,2'd3,4'h7,32'h00222120));
    vecs.push_back(mk(1,1,8'h24,4'h0, 1,1,3'd0,2'd0,4'hF,32'h23222120));
    vecs.push_back(mk(1,1,8'h25,4'h0, 1,1,3'd1,2'd1,4'hF,32'h23222120));
    vecs.push_back(mk(1,1,8'h26,4'h0, 1,1,3'd2,2'd2,4'hF,32'h23222120));
    vecs.push_back(mk(1,1,8'h27,4'h0, 1,1,3'd3,2'd3,4'hF,32'h23222120));
    vecs.push_back(mk(1,1,8'h28,4'h0, 1,0,3'd7,2'd0,4'hF,32'h23222120));
    vecs.push_back(mk(1,1,8'h28,4'h0, 1,0,3'd7,2'd0,4'hF,32'h23222120));
    // Pop of a full lane does not free it in the same cycle
    vecs.push_back(mk(1,1,8'h28,4'h1, 1,0,3'd7,2'd0,4'hF,32'h23222120));
    vecs.push_back(mk(1,1,8'h28,4'h0, 1,1,3'd0,2'd0,4'hF,32'h23222124));
    // Reset with everything full
    vecs.push_back(mk(0,0,8'h00,4'h0, 1,0,3'd7,2'd1,4'hF,32'h23222124));
    vecs.push_back(mk(1,0,8'h00,4'h0, 1,1,3'd7,2'd0,4'h0,32'h0));
    // Build lanes 0,1 full, lanes 2,3 empty, r_ptr = 0
    vecs.push_back(mk(1,1,8'h30,4'h0, 1,1,3'd0,2'd0,4'h0,32'h0));
    vecs.push_back(mk(1,1,8'h31,4'h0, 1,1,3'd1,2'd1,4'h1,32'h00000030));
    vecs.push_back(mk(1,1,8'h32,4'h0, 1,1,3'd2,2'd2,4'h3,32'h00003130));
    vecs.push_back(mk(1,1,8'h33,4'h0, 1,1,3'd3,2'd3,4'h7,32'h00323130));
    vecs.push_back(mk(1,1,8'h34,4'h0, 1,1,3'd0,2'd0,4'hF,32'h33323130));
    vecs.push_back(mk(1,1,8'h35,4'h0, 1,1,3'd1,2'd1,4'hF,32'h33323130));
    vecs.push_back(mk(1,1,8'h36,4'h0, 1,1,3'd2,2'd2,4'hF,32'h33323130));
    vecs.push_back(mk(1,1,8'h37,4'h0, 1,1,3'd3,2'd3,4'hF,32'h33323130));
    vecs.push_back(mk(1,0,8'h00,4'hC, 1,0,3'd7,2'd0,4'hF,32'h33323130));
    vecs.push_back(mk(1,0,8'h00,4'hC, 1,1,3'd7,2'd0,4'hF,32'h37363130));
    // Skip the two full lanes: word lands in lane 2, r_ptr -> 3
    vecs.push_back(mk(1,1,8'h40,4'h0, 1,1,3'd2,2'd0,4'h3,32'h00003130));
    vecs.push_back(mk(1,1,8'h41,4'h0, 1,1,3'd3,2'd3,4'h7,32'h00403130));
    vecs.push_back(mk(1,1,8'h42,4'h0, 1,1,3'd2,2'd0,4'hF,32'h41403130));
    // Only lane 3 free with r_ptr = 3: lands there, r_ptr wraps to 0
    vecs.push_back(mk(1,1,8'h43,4'h0, 1,1,3'd3,2'd3,4'hF,32'h41403130));
    vecs.push_back(mk(1,0,8'h00,4'h0, 1,0,3'd7,2'd0,4'hF,32'h41403130));
    // Prepare lane 2 full, lane 3 one entry, r_ptr = 2
    vecs.push_back(mk(1,0,8'h00,4'hB, 1,0,3'd7,2'd0,4'hF,32'h41403130));
    vecs.push_back(mk(1,1,8'h44,4'h0, 1,1,3'd0,2'd0,4'hF,32'h43403534));
    vecs.push_back(mk(1,1,8'h45,4'h0, 1,1,3'd1,2'd1,4'hF,32'h43403534));
    // Pop of full lane 2 alongside a push at r_ptr = 2: word goes to lane 3
    vecs.push_back(mk(1,1,8'h46,4'h4, 1,1,3'd3,2'd2,4'hF,32'h43403534));
    vecs.push_back(mk(1,0,8'h00,4'h0, 1,1,3'd7,2'd0,4'hF,32'h43423534));
    // Simultaneous push and pop on lane 2 keeps one entry, new word at head
    vecs.push_back(mk(1,1,8'h47,4'h4, 1,1,3'd2,2'd0,4'hF,32'h43423534));
    vecs.push_back(mk(1,0,8'h00,4'h0, 1,1,3'd7,2'd3,4'hF,32'h43473534));
    // Trim to five buffered words, then reset mid-stream
    vecs.push_back(mk(1,0,8'h00,4'h3, 1,1,3'd7,2'd3,4'hF,32'h43473534));
    vecs.push_back(mk(0,0,8'h00,4'h0, 1,1,3'd7,2'd3,4'hF,32'h43474544));
    vecs.push_back(mk(1,1,8'h50,4'h0, 1,1,3'd0,2'd0,4'h0,32'h0));
    vecs.push_back(mk(1,0,8'h00,4'h0, 1,1,3'd7,2'd1,4'h1,32'h00000050));
    // out_ready on empty lanes is ignored
    vecs.push_back(mk(1,0,8'h00,4'hE, 1,1,3'd7,2'd1,4'h1,32'h00000050));
    vecs.push_back(mk(1,0,8'h00,4'h0, 1,1,3'd7,2'd1,4'h1,32'h00000050));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      if (vecs[i].chk) begin
        nvec++;
        cmp("in_ready",  i, 32'(in_ready),          32'(vecs[i].rdy));
        cmp("sel",       i, 32'(sel),               32'(vecs[i].sel));
        cmp("r_ptr",     i, 32'(dut.r_ptr_q),       32'(vecs[i].rptr));
        cmp("out_valid", i, 32'(out_valid),         32'(vecs[i].ov));
        for (int l = 0; l < 4; l++) begin
          if (vecs[i].ov[l])
            cmp($sformatf("out_data[%0d]", l), i, 32'(out_data[l*8 +: 8]),
                32'(vecs[i].od[l*8 +: 8]));
        end
      end
    end

    // Fill all lanes, confirm in_ready is low regardless of in_valid,
    // then drain lane by lane and check FIFO order.
    drive(0, 0, 8'h00, 4'h0);
    for (int k = 0; k < 8; k++) drive(1, 1, 8'(8'h60 + k), 4'h0);
    drive(1, 0, 8'h00, 4'h0);
    nvec++;
    cmp("full in_ready iv0", 100, 32'(in_ready), 32'd0);
    cmp("full sel iv0",      100, 32'(sel),      32'd7);
    drive(1, 1, 8'h99, 4'h0);
    nvec++;
    cmp("full in_ready iv1", 101, 32'(in_ready), 32'd0);
    cmp("full sel iv1",      101, 32'(sel),      32'd7);
    for (int l = 0; l < 4; l++) begin
      drive(1, 0, 8'h00, 4'(1 << l));
      nvec++;
      cmp("drain head0", 110 + l, 32'(out_data[l*8 +: 8]), 32'(8'h60 + l));
      drive(1, 0, 8'h00, 4'(1 << l));
      nvec++;
      cmp("drain head1", 120 + l, 32'(out_data[l*8 +: 8]), 32'(8'h64 + l));
      cmp("drain valid", 120 + l, 32'(out_valid[l]),       32'd1);
      drive(1, 0, 8'h00, 4'h0);
      nvec++;
      cmp("drain empty", 130 + l, 32'(out_valid[l]),       32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule
